// File: rtl/alu_pipe.sv
// Handshaked ALU: one operation per valid/ready transfer, result and flags held until accepted.
// Define ALU_FAST_SHIFT_EN for a single-cycle barrel shifter; default shifts iterate one bit per cycle.
module alu_pipe #(
   parameter int N_BUS = 8,
   parameter int N_OP  = 6
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   input  logic                    i_valid,
   output logic                    o_ready,
   input  logic signed [N_BUS-1:0] i_A,
   input  logic signed [N_BUS-1:0] i_B,
   input  logic [N_OP-1:0]         i_OP,
   output logic                    o_valid,
   input  logic                    i_ready,
   output logic signed [N_BUS-1:0] o_RES,
   output logic                    o_zero,
   output logic                    o_neg,
   output logic                    o_carry,
   output logic                    o_ovf,
   output logic                    o_err
);

   localparam logic [N_OP-1:0] OP_ADD = N_OP'(6'b100000);
   localparam logic [N_OP-1:0] OP_SUB = N_OP'(6'b100010);
   localparam logic [N_OP-1:0] OP_AND = N_OP'(6'b100100);
   localparam logic [N_OP-1:0] OP_OR  = N_OP'(6'b100101);
   localparam logic [N_OP-1:0] OP_XOR = N_OP'(6'b100110);
   localparam logic [N_OP-1:0] OP_NOR = N_OP'(6'b100111);
   localparam logic [N_OP-1:0] OP_SLL = N_OP'(6'b000000);
   localparam logic [N_OP-1:0] OP_SRL = N_OP'(6'b000010);
   localparam logic [N_OP-1:0] OP_SRA = N_OP'(6'b000011);
   localparam logic [N_OP-1:0] OP_SLT = N_OP'(6'b101010);
   localparam logic [N_BUS-1:0] NB    = N_BUS'(N_BUS);

`ifdef ALU_FAST_SHIFT_EN
   typedef enum logic {IDLE, HOLD} state_t;
`else
   typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;
   localparam int CW = $clog2(N_BUS + 1);
`endif

   // Any amount of N_BUS or more behaves exactly like N_BUS.
   function automatic logic [N_BUS-1:0] sat_amt(input logic [N_BUS-1:0] b);
      sat_amt = (b > NB) ? NB : b;
   endfunction

`ifdef ALU_FAST_SHIFT_EN
   function automatic logic [N_BUS-1:0] barrel(input logic [N_OP-1:0] op,
                                                input logic [N_BUS-1:0] v,
                                                input logic [N_BUS-1:0] k);
      case (op)
         OP_SLL:  barrel = v << k;
         OP_SRA:  barrel = $unsigned($signed(v) >>> k);
         default: barrel = v >> k;
      endcase
   endfunction
`else
   function automatic logic [N_BUS-1:0] shift_step(input logic [N_OP-1:0] op,
                                                    input logic [N_BUS-1:0] v);
      case (op)
         OP_SLL:  shift_step = {v[N_BUS-2:0], 1'b0};
         OP_SRA:  shift_step = {v[N_BUS-1], v[N_BUS-1:1]};
         default: shift_step = {1'b0, v[N_BUS-1:1]};
      endcase
   endfunction
`endif

   state_t state, state_n;

   logic              accept;
   logic              load_alu;
   logic [N_BUS-1:0]  amt;
   logic [N_BUS:0]    sum, diff;
   logic [N_BUS-1:0]  alu_res;
   logic              alu_carry, alu_ovf, alu_err;

   logic [N_BUS-1:0]  res_p1;
   logic              zero_p1, neg_p1, carry_p1, ovf_p1, err_p1;

   assign o_ready = (state == IDLE) || (state == HOLD && i_ready);
   assign o_valid = (state == HOLD);
   assign accept  = i_valid && o_ready;
   assign amt     = sat_amt($unsigned(i_B));

`ifdef ALU_FAST_SHIFT_EN
   assign load_alu = accept;
`else
   logic              is_shift, load_shift, shift_done;
   logic [N_BUS-1:0]  sh_p0, step_res;
   logic [CW-1:0]     cnt_p0;
   logic [N_OP-1:0]   sop_p0;

   assign is_shift   = (i_OP == OP_SLL) || (i_OP == OP_SRL) || (i_OP == OP_SRA);
   assign load_shift = accept && is_shift && (amt != '0);
   assign load_alu   = accept && !load_shift;
   assign step_res   = shift_step(sop_p0, sh_p0);
   assign shift_done = (state == SHIFT) && (cnt_p0 == CW'(1));
`endif

   always_comb begin
      sum       = {1'b0, $unsigned(i_A)} + {1'b0, $unsigned(i_B)};
      diff      = {1'b0, $unsigned(i_A)} - {1'b0, $unsigned(i_B)};
      alu_res   = '0;
      alu_carry = 1'b0;
      alu_ovf   = 1'b0;
      alu_err   = 1'b0;
      case (i_OP)
         OP_ADD: begin
            alu_res   = sum[N_BUS-1:0];
            alu_carry = sum[N_BUS];
            alu_ovf   = (i_A[N_BUS-1] == i_B[N_BUS-1]) && (sum[N_BUS-1] != i_A[N_BUS-1]);
         end
         OP_SUB: begin
            alu_res   = diff[N_BUS-1:0];
            alu_carry = diff[N_BUS];
            alu_ovf   = (i_A[N_BUS-1] != i_B[N_BUS-1]) && (diff[N_BUS-1] != i_A[N_BUS-1]);
         end
         OP_AND: alu_res = i_A & i_B;
         OP_OR:  alu_res = i_A | i_B;
         OP_XOR: alu_res = i_A ^ i_B;
         OP_NOR: alu_res = ~(i_A | i_B);
         // Direct signed compare, so an overflowing A-B cannot flip the answer.
         OP_SLT: alu_res = {{(N_BUS-1){1'b0}}, (i_A < i_B)};
`ifdef ALU_FAST_SHIFT_EN
         OP_SLL, OP_SRL, OP_SRA: alu_res = barrel(i_OP, i_A, amt);
`else
         OP_SLL, OP_SRL, OP_SRA: alu_res = i_A;
`endif
         default: alu_err = 1'b1;
      endcase
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE: begin
`ifdef ALU_FAST_SHIFT_EN
            if (accept) state_n = HOLD;
`else
            if (accept) state_n = load_shift ? SHIFT : HOLD;
         end
         SHIFT: begin
            if (cnt_p0 == CW'(1)) state_n = HOLD;
`endif
         end
         HOLD: begin
`ifdef ALU_FAST_SHIFT_EN
            if (i_ready) state_n = i_valid ? HOLD : IDLE;
`else
            if (i_ready) state_n = i_valid ? (load_shift ? SHIFT : HOLD) : IDLE;
`endif
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) state <= IDLE;
      else          state <= state_n;
   end

   // Result stage: loaded at accept for single-cycle ops, or when the shifter finishes.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         res_p1   <= '0;
         zero_p1  <= 1'b0;
         neg_p1   <= 1'b0;
         carry_p1 <= 1'b0;
         ovf_p1   <= 1'b0;
         err_p1   <= 1'b0;
      end else if (load_alu) begin
         res_p1   <= alu_res;
         zero_p1  <= (alu_res == '0);
         neg_p1   <= alu_res[N_BUS-1];
         carry_p1 <= alu_carry;
         ovf_p1   <= alu_ovf;
         err_p1   <= alu_err;
`ifndef ALU_FAST_SHIFT_EN
      end else if (shift_done) begin
         res_p1   <= step_res;
         zero_p1  <= (step_res == '0);
         neg_p1   <= step_res[N_BUS-1];
         carry_p1 <= 1'b0;
         ovf_p1   <= 1'b0;
         err_p1   <= 1'b0;
`endif
      end
   end

`ifndef ALU_FAST_SHIFT_EN
   // Shift stage: working value and remaining bit count.
   always_ff @(posedge i_clk) begin
      if (load_shift) begin
         sh_p0  <= i_A;
         cnt_p0 <= amt[CW-1:0];
         sop_p0 <= i_OP;
      end else if (state == SHIFT) begin
         sh_p0  <= step_res;
         cnt_p0 <= cnt_p0 - CW'(1);
      end
   end
`endif

   assign o_RES   = res_p1;
   assign o_zero  = zero_p1;
   assign o_neg   = neg_p1;
   assign o_carry = carry_p1;
   assign o_ovf   = ovf_p1;
   assign o_err   = err_p1;

endmodule
